// File: rtl/ddr_rd_uart_streamer_pkg.sv
// Shared definitions for the DDR read to UART streamer: MIG command codes,
// default address step and the issuer/serializer state encodings.
package ddr_rd_uart_streamer_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // One app word covers 8 DRAM addresses in 4:1 mode with x16 parts
  localparam int ADDR_STEP = 8;

  typedef enum logic {
    I_IDLE = 1'b0,
    I_REQ  = 1'b1
  } issue_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ddr_rd_uart_streamer_word_fifo2.sv
// Two-entry word FIFO holding read data between the MIG and the byte serializer.
// Head is the oldest entry; simultaneous push and pop keep the count unchanged.
module word_fifo2 #(
  parameter int p_DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [p_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [p_DATA_WIDTH-1:0] head,
  output logic [1:0]              count
);

  logic [p_DATA_WIDTH-1:0] mem [2];
  logic                    rd_ptr;
  logic                    wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the count decides what is meaningful
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ddr_rd_uart_streamer.sv
// Reads an inclusive range of MIG app words and streams each word MSB byte first
// to UART_TX_CTRL, keeping at most two words in flight or buffered.
module ddr_rd_uart_streamer
  import ddr_rd_uart_streamer_pkg::*;
#(
  parameter int p_ADDR_WIDTH = 28,
  parameter int p_DATA_WIDTH = 128,
  parameter int p_ADDR_STEP  = ADDR_STEP
) (
  input  logic                    IN_CLK,
  input  logic                    IN_RST_N,
  input  logic                    IN_START,
  input  logic [p_ADDR_WIDTH-1:0] IN28_START_ADDR,
  input  logic [p_ADDR_WIDTH-1:0] IN28_END_ADDR,
  output logic                    OUT_BUSY,
  output logic                    OUT_DONE,
  output logic [p_ADDR_WIDTH-1:0] OUT28_APP_ADDR,
  output logic [2:0]              OUT3_APP_CMD,
  output logic                    OUT_APP_EN,
  input  logic                    IN_APP_RDY,
  input  logic [p_DATA_WIDTH-1:0] IN128_APP_RD_DATA,
  input  logic                    IN_APP_RD_DATA_VALID,
  output logic                    OUT_UART_TX_SEND,
  output logic [7:0]              OUT8_UART_TX_DATA,
  input  logic                    IN_UART_TX_READY,
  input  logic                    IN_UART_TX_BYTE_DONE
);

  localparam int NBYTES = p_DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE  = IDX_W'(1);
  localparam logic [p_ADDR_WIDTH-1:0] STEP     = p_ADDR_WIDTH'(p_ADDR_STEP);
  localparam logic [p_ADDR_WIDTH-1:0] ONE      = p_ADDR_WIDTH'(1);
  localparam logic [p_ADDR_WIDTH-1:0] ALIGN    = ~p_ADDR_WIDTH'(7);

  issue_state_t istate, istate_nxt;
  ser_state_t   sstate, sstate_nxt;

  logic                    busy;
  logic                    done;
  logic [p_ADDR_WIDTH-1:0] addr;
  logic [p_ADDR_WIDTH-1:0] issue_left;
  logic [p_ADDR_WIDTH-1:0] pop_left;
  logic [1:0]              outstanding;
  logic [IDX_W-1:0]        idx;

  logic [p_ADDR_WIDTH-1:0] start_a;
  logic [p_ADDR_WIDTH-1:0] end_a;
  logic [p_ADDR_WIDTH-1:0] word_cnt;
  logic                    start_ok;
  logic                    range_ok;
  logic                    cmd_acc;
  logic                    push;
  logic                    pop;
  logic [2:0]              inflight;
  logic [1:0]              fifo_count;
  logic [p_DATA_WIDTH-1:0] head;

  assign start_a  = IN28_START_ADDR & ALIGN;
  assign end_a    = IN28_END_ADDR & ALIGN;
  assign start_ok = IN_START & ~busy;
  assign range_ok = (end_a >= start_a);
  assign word_cnt = (end_a - start_a) / STEP + ONE;
  assign cmd_acc  = (istate == I_REQ) && IN_APP_RDY;
  // Data arriving with nothing outstanding belongs to an aborted transfer
  assign push     = IN_APP_RD_DATA_VALID && (outstanding != 2'd0);
  assign pop      = (sstate == S_WAIT) && IN_UART_TX_BYTE_DONE && (idx == '0);
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};

  word_fifo2 #(
    .p_DATA_WIDTH(p_DATA_WIDTH)
  ) u_fifo (
    .clk      (IN_CLK),
    .rst_n    (IN_RST_N),
    .push     (push),
    .push_data(IN128_APP_RD_DATA),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      istate <= I_IDLE;
      sstate <= S_IDLE;
    end else begin
      istate <= istate_nxt;
      sstate <= sstate_nxt;
    end
  end

  // Issue only while the read in flight plus buffered words leave a free slot
  always_comb begin
    istate_nxt = istate;
    case (istate)
      I_IDLE: begin
        if (start_ok && range_ok) begin
          istate_nxt = I_REQ;
        end else if (busy && (issue_left != '0) && (inflight < 3'd2)) begin
          istate_nxt = I_REQ;
        end
      end
      I_REQ: begin
        if (IN_APP_RDY) istate_nxt = I_IDLE;
      end
      default: istate_nxt = I_IDLE;
    endcase
  end

  // Entering on a same-cycle push lets the first byte go out one cycle after valid data
  always_comb begin
    sstate_nxt = sstate;
    case (sstate)
      S_IDLE: begin
        if ((fifo_count != 2'd0) || push) sstate_nxt = S_SEND;
      end
      S_SEND: begin
        if (IN_UART_TX_READY) sstate_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (IN_UART_TX_BYTE_DONE) sstate_nxt = (idx == '0) ? S_IDLE : S_SEND;
      end
      default: sstate_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    OUT_BUSY          = busy;
    OUT_DONE          = done;
    OUT28_APP_ADDR    = addr;
    OUT3_APP_CMD      = CMD_READ;
    OUT_APP_EN        = (istate == I_REQ);
    OUT_UART_TX_SEND  = 1'b0;
    OUT8_UART_TX_DATA = 8'h00;
    if ((sstate == S_SEND) && IN_UART_TX_READY) begin
      OUT_UART_TX_SEND  = 1'b1;
      OUT8_UART_TX_DATA = head[{idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      addr        <= '0;
      issue_left  <= '0;
      pop_left    <= '0;
      outstanding <= 2'd0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        if (range_ok) begin
          busy       <= 1'b1;
          addr       <= start_a;
          issue_left <= word_cnt;
          pop_left   <= word_cnt;
        end else begin
          done <= 1'b1;
        end
      end
      if (cmd_acc) begin
        addr       <= addr + STEP;
        issue_left <= issue_left - ONE;
      end
      case ({cmd_acc, push})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
      if (pop) begin
        pop_left <= pop_left - ONE;
        if (pop_left == ONE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      idx <= '0;
    end else if ((sstate == S_IDLE) && (sstate_nxt == S_SEND)) begin
      idx <= LAST_IDX;
    end else if ((sstate == S_WAIT) && IN_UART_TX_BYTE_DONE) begin
      idx <= idx - IDX_ONE;
    end
  end

endmodule

// File: doc/ddr_rd_uart_streamer.md
# ddr_rd_uart_streamer

Streams a contiguous range of 128-bit DDR3 words from the MIG user interface to the UART transmitter, sending each word's 16 bytes MSB-first. Sits downstream of the MIG app read port and upstream of UART_TX_CTRL, and replaces the inline read/TX loop in mig_top. A two-word prefetch buffer lets the next MIG read complete while the current word is still being serialized.

## Interface
Parameters:
- p_ADDR_WIDTH, 28, MIG app address width
- p_DATA_WIDTH, 128, MIG app data width; must be a multiple of 8
- p_ADDR_STEP, 8, address increment per app word (4:1 mode, x16 DRAM)

Ports:
- IN_CLK  in  1  ui_clk; the only clock
- IN_RST_N  in  1  reset, asynchronous, active-low
- IN_START  in  1  one-cycle start strobe; ignored while OUT_BUSY=1
- IN28_START_ADDR  in  p_ADDR_WIDTH  first word address; sampled on accepted IN_START
- IN28_END_ADDR  in  p_ADDR_WIDTH  last word address, inclusive; sampled on accepted IN_START
- OUT_BUSY  out  1  transfer in progress
- OUT_DONE  out  1  one-cycle pulse when the transfer completes
- OUT28_APP_ADDR  out  p_ADDR_WIDTH  MIG app_addr
- OUT3_APP_CMD  out  3  MIG app_cmd; constant 3'b001 (READ)
- OUT_APP_EN  out  1  MIG app_en
- IN_APP_RDY  in  1  MIG app_rdy
- IN128_APP_RD_DATA  in  p_DATA_WIDTH  MIG app_rd_data
- IN_APP_RD_DATA_VALID  in  1  MIG app_rd_data_valid
- OUT_UART_TX_SEND  out  1  one-cycle send strobe to UART_TX_CTRL
- OUT8_UART_TX_DATA  out  8  byte to transmit
- IN_UART_TX_READY  in  1  UART transmitter idle
- IN_UART_TX_BYTE_DONE  in  1  UART byte-complete pulse

## Operation
- Reset values: OUT_BUSY=0, OUT_DONE=0, OUT_APP_EN=0, OUT28_APP_ADDR=0, OUT3_APP_CMD=3'b001, OUT_UART_TX_SEND=0, OUT8_UART_TX_DATA=0. Internal occupancy, outstanding count, and byte index are cleared.
- Address bits [2:0] of both inputs are forced to 0.
- Accepted IN_START with END >= START: word count = (END-START)/p_ADDR_STEP + 1. BUSY goes high, and the issue address is set to START.
- Accepted IN_START with END < START: no MIG or UART traffic. DONE pulses and BUSY stays 0.
- Issuer (states I_IDLE, I_REQ):
  - Enter I_REQ when words remain to issue and outstanding + buffer occupancy < 2.
  - In I_REQ, OUT_APP_EN is held high with ADDR stable until IN_APP_RDY=1. The cycle with both high is the accepted command.
  - On acceptance: outstanding +1, ADDR += p_ADDR_STEP (mod 2^p_ADDR_WIDTH), go to I_IDLE.
- Capture: IN_APP_RD_DATA_VALID with outstanding > 0 pushes the data into the 2-entry buffer and decrements outstanding.
  - Valid with outstanding = 0 (stale data after reset) is dropped.
- Serializer (states S_IDLE, S_SEND, S_WAIT):
  - S_IDLE → S_SEND when the buffer is non-empty, with byte index = 15.
  - S_SEND: when IN_UART_TX_READY=1, drive DATA = head[index*8 +: 8] with SEND=1 for one cycle, then go to S_WAIT.
  - S_WAIT: on IN_UART_TX_BYTE_DONE, index -1. Return to S_SEND if the index was nonzero. Otherwise pop the head and go to S_IDLE.
- Completion: after the last word is popped, DONE pulses for one cycle and BUSY drops in the same cycle.
- Simultaneous push and pop keep occupancy unchanged. Push is never blocked, because the issue rule guarantees buffer space.
- Reset mid-transfer aborts immediately: all outputs return to reset values and any partial byte sequence is abandoned.

## Timing
- Accepted IN_START at cycle 0 → OUT_APP_EN=1 at cycle 1.
- Valid read data at cycle k, serializer idle, TX ready → SEND at k+1.
- BYTE_DONE at cycle m → next SEND at m+1 (if TX ready). After the final byte, DONE at m+1.
- At most 2 reads are in flight or buffered at any time. Word n+1's read is issued while word n is being serialized.
- OUT_APP_EN never deasserts without IN_APP_RDY. OUT28_APP_ADDR changes only after acceptance.

## Structure
- Shared package: MIG command encodings (CMD_WRITE=3'b000, CMD_READ=3'b001), ADDR_STEP, and issuer/serializer state encodings.
- Sub-module: word_fifo2, a 2-entry p_DATA_WIDTH FIFO with push, pop, head, and count outputs.

## Test plan
- START=0x000, END=0x000; data 0x00112233_44556677_8899AABB_CCDDEEFF → bytes 0x00..0xFF sent in order, then one DONE pulse.
- START=0x010, END=0x028 (4 words); APP_RDY stalled 5 cycles per command → EN held and ADDR stable during each stall; addresses 0x10, 0x18, 0x20, 0x28 issued; 64 bytes sent in order.
- Rd latency 20 cycles, TX byte time 100 cycles → outstanding + occupancy never exceeds 2; the second read is issued before word 0's last byte is sent.
- START=0x040, END=0x038 → DONE at cycle 1, no EN, no SEND, BUSY stays 0.
- IN_RST_N low mid-word 2, then a stale RD_DATA_VALID arrives → outputs at reset values; stale data dropped; a fresh START behaves normally.
- IN_START pulsed while BUSY=1 → ignored; the transfer range is unchanged.
